// File: rtl/serializer.sv
// Packet-to-AXI serializer: latches one selector packet and issues it as a single
// AXI write (AW, W beats, B) or read-address (AR) transaction, then pulses consumed.
module serializer #(
   parameter int unsigned DATA_SIZE    = 678,
   parameter int unsigned ADDR_WIDTH   = 40,
   parameter int unsigned AXI_ID_WIDTH = 16,
   parameter int unsigned DATA_WIDTH   = 128,
   parameter int unsigned MAX_BEATS    = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [DATA_SIZE-1:0]    packet,
   input  logic                    enable,
   output logic                    consumed,
   output logic                    busy,
   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]              m_axi_awlen,
   output logic [2:0]              m_axi_awsize,
   output logic [1:0]              m_axi_awburst,
   output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wlast,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic [7:0]              m_axi_arlen,
   output logic [2:0]              m_axi_arsize,
   output logic [1:0]              m_axi_arburst,
   output logic [AXI_ID_WIDTH-1:0] m_axi_arid,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready
);

   localparam int unsigned HDR_W    = 102;
   localparam int unsigned STRB_W   = DATA_WIDTH / 8;
   localparam int unsigned STRB_LSB = HDR_W;
   localparam int unsigned DATA_LSB = HDR_W + MAX_BEATS * STRB_W;
   localparam int unsigned CNT_W    = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
   localparam int unsigned LEN_MAX  = MAX_BEATS - 1;
   localparam int unsigned WR_BIT   = 81;

   typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR} state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        w_cnt_nxt;
   logic                    w_latch;
   logic                    w_consumed_nxt;

   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_len;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic [AXI_ID_WIDTH-1:0] r_id;
   logic [STRB_W-1:0]       r_strb [MAX_BEATS];
   logic [DATA_WIDTH-1:0]   r_data [MAX_BEATS];

   logic                    r_awvalid;
   logic                    r_wvalid;
   logic                    r_bready;
   logic                    r_arvalid;
   logic                    r_busy;
   logic                    r_consumed;
   logic                    r_wlast;
   logic [DATA_WIDTH-1:0]   r_wdata;
   logic [STRB_W-1:0]       r_wstrb;

   logic [7:0]              w_pkt_len;
   logic [7:0]              w_len_eff;
   logic [STRB_W-1:0]       w_strb [MAX_BEATS];
   logic [DATA_WIDTH-1:0]   w_data [MAX_BEATS];
   logic                    w_unused;

   // Header bits the serializer never acts on, plus the write response code.
   assign w_unused = ^{m_axi_bresp, packet[80:69], packet[101:82]};

   assign w_pkt_len = packet[47:40];
   assign w_len_eff = (w_pkt_len > 8'(LEN_MAX)) ? 8'(LEN_MAX) : w_pkt_len;

   for (genvar k = 0; k < MAX_BEATS; k++) begin : g_unpack
      assign w_strb[k] = packet[STRB_LSB + k*STRB_W +: STRB_W];
      assign w_data[k] = packet[DATA_LSB + k*DATA_WIDTH +: DATA_WIDTH];
   end

   // Next-state logic; IDLE skips the consumed cycle so the scheduler can advance.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_latch        = 1'b0;
      w_consumed_nxt = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enable && !r_consumed) begin
               w_latch     = 1'b1;
               w_state_nxt = packet[WR_BIT] ? S_AW : S_AR;
            end
         end
         S_AW: begin
            if (m_axi_awready) begin
               w_state_nxt = S_W;
               w_cnt_nxt   = '0;
            end
         end
         S_W: begin
            if (m_axi_wready) begin
               if (r_wlast) w_state_nxt = S_B;
               else         w_cnt_nxt   = CNT_W'(r_cnt + 1'b1);
            end
         end
         S_B: begin
            if (m_axi_bvalid) begin
               w_state_nxt    = S_IDLE;
               w_consumed_nxt = 1'b1;
            end
         end
         S_AR: begin
            if (m_axi_arready) begin
               w_state_nxt    = S_IDLE;
               w_consumed_nxt = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_bready   <= 1'b0;
         r_arvalid  <= 1'b0;
         r_busy     <= 1'b0;
         r_consumed <= 1'b0;
         r_wlast    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_awvalid  <= (w_state_nxt == S_AW);
         r_wvalid   <= (w_state_nxt == S_W);
         r_bready   <= (w_state_nxt == S_B);
         r_arvalid  <= (w_state_nxt == S_AR);
         r_busy     <= (w_state_nxt != S_IDLE);
         r_consumed <= w_consumed_nxt;
         r_wlast    <= (8'(w_cnt_nxt) == r_len);
      end
   end

   // Payload holding registers; contents are only observed while a valid is high.
   always_ff @(posedge clock) begin
      if (w_latch && reset) begin
         r_addr  <= packet[ADDR_WIDTH-1:0];
         r_len   <= w_len_eff;
         r_size  <= packet[50:48];
         r_burst <= packet[52:51];
         r_id    <= packet[68:53];
         r_strb  <= w_strb;
         r_data  <= w_data;
      end
      r_wdata <= r_data[w_cnt_nxt];
      r_wstrb <= r_strb[w_cnt_nxt];
   end

   assign consumed      = r_consumed;
   assign busy          = r_busy;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awlen   = r_len;
   assign m_axi_awsize  = r_size;
   assign m_axi_awburst = r_burst;
   assign m_axi_awid    = r_id;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_wdata   = r_wdata;
   assign m_axi_wstrb   = r_wstrb;
   assign m_axi_wlast   = r_wlast;
   assign m_axi_wvalid  = r_wvalid;
   assign m_axi_bready  = r_bready;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arlen   = r_len;
   assign m_axi_arsize  = r_size;
   assign m_axi_arburst = r_burst;
   assign m_axi_arid    = r_id;
   assign m_axi_arvalid = r_arvalid;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: Serializer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 678, meaning packet width: 102-bit header + 4x16-bit strobes + 4x128-bit data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 40, meaning AXI address width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 16, meaning AXI ID width.
REQ-004 SHALL have parameter DATA_WIDTH, default 128, meaning AXI data beat width.
REQ-005 SHALL have parameter MAX_BEATS, default 4, meaning data beats carried per packet.
REQ-006 SHALL have port clock, in, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port reset, in, 1: synchronous, active-low reset.
REQ-008 SHALL have port packet, in, DATA_SIZE: packet from the selector.
REQ-009 SHALL have port enable, in, 1: scheduler indicates packet is valid and stable.
REQ-010 SHALL have port consumed, out, 1: one-cycle pulse when the packet is fully issued.
REQ-011 SHALL have port busy, out, 1: high whenever state is not IDLE.
REQ-012 SHALL have ports m_axi_awaddr/awlen/awsize/awburst/awid, out, ADDR_WIDTH/8/3/2/AXI_ID_WIDTH: write-address fields.
REQ-013 SHALL have ports m_axi_awvalid out 1 and m_axi_awready in 1: AW handshake.
REQ-014 SHALL have ports m_axi_wdata/wstrb/wlast, out, DATA_WIDTH/DATA_WIDTH/8/1: write-data fields.
REQ-015 SHALL have ports m_axi_wvalid out 1 and m_axi_wready in 1: W handshake.
REQ-016 SHALL have ports m_axi_bresp in 2, m_axi_bvalid in 1 and m_axi_bready out 1: write response.
REQ-017 SHALL have ports m_axi_araddr/arlen/arsize/arburst/arid, out, same widths as AW: read-address fields.
REQ-018 SHALL have ports m_axi_arvalid out 1 and m_axi_arready in 1: AR handshake.

Function
REQ-019 SHALL decode header bits as: addr[39:0], len[47:40], size[50:48], burst[52:51], id[68:53], is_write[81]; bits [80:69] and [101:82] are ignored.
REQ-020 SHALL take strobe k from packet[102+16k +:16] and data beat k from packet[166+128k +:128], for k=0..3.
REQ-021 SHALL implement states IDLE, AW, W, B, AR.
REQ-022 In IDLE with enable=1 and consumed=0, SHALL latch packet and go to AW if is_write=1, else AR; packet is not sampled in any other state.
REQ-023 In AW, SHALL drive awvalid=1 with latched fields; on awready go to W with beat counter=0.
REQ-024 In W, SHALL drive wvalid=1, wdata/wstrb = beat[counter], wlast=(counter==eff_len); on wready at wlast go to B, otherwise increment counter.
REQ-025 SHALL use eff_len = min(len, MAX_BEATS-1); awlen/arlen SHALL output eff_len.
REQ-026 In B, SHALL drive bready=1; on bvalid go to IDLE and pulse consumed in the next cycle. bresp is ignored for control.
REQ-027 In AR, SHALL drive arvalid=1; on arready go to IDLE and pulse consumed in the next cycle.
REQ-028 consumed SHALL be registered, high for exactly one cycle; enable in that cycle SHALL be ignored so the scheduler can advance.
REQ-029 valid signals SHALL stay high with stable payload until their handshake completes; valid SHALL never depend combinationally on ready.
REQ-030 Latency with all readies high: enable sampled at cycle 0 -> awvalid at 1 -> W beats 2..2+eff_len -> consumed one cycle after bvalid is sampled.

Reset
REQ-031 When reset=0 at a clock edge, SHALL enter IDLE; all valids, bready, consumed, busy = 0; beat counter = 0; any in-flight transaction is abandoned.
REQ-032 Reset SHALL override enable and all handshakes in the same cycle.

Verification
REQ-033 Write with len=3 and all readies high; bvalid returned 1 cycle after wlast -> awvalid at cycle 1, wdata beats 0..3 at cycles 2..5 with wlast at 5, consumed pulse at cycle 7.
REQ-034 Read to addr 0x1000 with id=5 and arready delayed 3 cycles -> araddr/arid stable for 4 cycles, consumed pulses once, no AW/W activity.
REQ-035 Write with wready toggling 1/0 -> each beat is held until accepted; beat order is 0,1,2,3; strobes match.
REQ-036 len=7 -> awlen=3, exactly 4 beats issued.
REQ-037 enable held high across two packets -> the second packet is latched only after the consumed cycle; no duplicate issue.
REQ-038 reset=0 asserted during beat 2 of W -> the next cycle is IDLE with wvalid=0 and no consumed pulse; a fresh packet then issues normally.
